lsu_mem_master: RTL

Load/store initiator that drives the byte-addressed data memory port from the MEM pipeline stage. It accepts one load or store request per transaction, encodes RISC-V funct3 into the memory size select, and issues a single-cycle access. Load data is sign- or zero-extended before being returned. Out-of-range and illegal requests are rejected with an error response, and memory is never touched for them.

---
 rtl/lsu_mem_master.sv | 133 +++++++++++++
 1 files changed

// File: rtl/lsu_mem_master.sv
// rtl/lsu_mem_master.sv - load/store initiator driving the byte-addressed data memory port
// Optional build macro LSU_MISALIGN_TRAP_EN: reject misaligned halfword/word requests.
module lsu_mem_master #(
   parameter int unsigned DROM_SPACE = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] data_addr,
   output logic [31:0] w_data_mem,
   output logic        r_en_mem,
   output logic        w_en_mem,
   output logic [1:0]  byte_sel,
   input  logic [31:0] r_data_mem
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t      state_q;
   logic        ready_q, resp_valid_q, resp_err_q, r_en_q, w_en_q, we_q;
   logic [2:0]  funct3_q;
   logic [31:0] addr_q, wdata_q, rdata_q;

   logic        f3_legal, range_err, misalign_err, req_err;
   logic [2:0]  size_m1;
   logic [32:0] last_addr;
   logic [31:0] load_ext;

   always_comb begin
      if (req_we) f3_legal = (req_funct3 inside {3'b000, 3'b001, 3'b010});
      else        f3_legal = (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      case (req_funct3[1:0])
         2'b00:   size_m1 = 3'd0;
         2'b01:   size_m1 = 3'd1;
         default: size_m1 = 3'd3;
      endcase
      // 33-bit sum so an access wrapping past 2^32 still lands out of range
      last_addr = {1'b0, req_addr} + {30'd0, size_m1};
      range_err = last_addr > 33'(DROM_SPACE - 1);
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_err = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
      misalign_err = 1'b0;
`endif
      req_err = !f3_legal || range_err || misalign_err;
   end

   always_comb begin
      case (funct3_q)
         3'b000:  load_ext = {{24{r_data_mem[7]}}, r_data_mem[7:0]};
         3'b001:  load_ext = {{16{r_data_mem[15]}}, r_data_mem[15:0]};
         3'b100:  load_ext = {24'd0, r_data_mem[7:0]};
         3'b101:  load_ext = {16'd0, r_data_mem[15:0]};
         default: load_ext = r_data_mem;
      endcase
   end

   // ready_q is registered, so the first cycle after reset never accepts a request
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         ready_q      <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         r_en_q       <= 1'b0;
         w_en_q       <= 1'b0;
         we_q         <= 1'b0;
         funct3_q     <= 3'd0;
         addr_q       <= 32'd0;
         wdata_q      <= 32'd0;
         rdata_q      <= 32'd0;
      end else begin
         case (state_q)
            IDLE: begin
               ready_q <= 1'b1;
               if (ready_q && req_valid) begin
                  ready_q    <= 1'b0;
                  we_q       <= req_we;
                  funct3_q   <= req_funct3;
                  addr_q     <= req_addr;
                  wdata_q    <= req_wdata;
                  rdata_q    <= 32'd0;
                  resp_err_q <= req_err;
                  if (req_err) begin
                     state_q      <= RESP;
                     resp_valid_q <= 1'b1;
                  end else begin
                     state_q <= ACCESS;
                     r_en_q  <= !req_we;
                     w_en_q  <= req_we;
                  end
               end
            end
            ACCESS: begin
               r_en_q       <= 1'b0;
               w_en_q       <= 1'b0;
               if (!we_q) rdata_q <= load_ext;
               state_q      <= RESP;
               resp_valid_q <= 1'b1;
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid_q <= 1'b0;
                  ready_q      <= 1'b1;
                  state_q      <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready  = ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_rdata = rdata_q;
   assign data_addr  = addr_q;
   assign w_data_mem = wdata_q;
   assign byte_sel   = funct3_q[1:0];
   assign r_en_mem   = r_en_q;
   assign w_en_mem   = w_en_q;

endmodule
